// File: rtl/multimem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multimem_pkg
// Description : Shared widths and FSM state encoding for the multi-requester
//               byte-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package multimem_pkg;

    localparam int c_addr_w = 8;
    localparam int c_data_w = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mm_state_e;

endpackage : multimem_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans the request vector
//               starting at the priority pointer and returns the first set
//               bit as one-hot, as an index, and an any-valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PW-1:0]    idx_o,
    output logic             valid_o
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_pos;
    logic          w_found;

    // Walk ptr, ptr+1, ... (mod N_REQ) and keep the first requester found
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, ptr_i} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(N_REQ)) begin
                w_sum = w_sum - (PW+1)'(N_REQ);
            end
            w_pos = w_sum[PW-1:0];
            if (!w_found && req_i[w_pos]) begin
                w_found        = 1'b1;
                grant_o[w_pos] = 1'b1;
                idx_o          = w_pos;
            end
        end
        valid_o = w_found;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/multimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : multimem_arbiter
// Description : Round-robin arbiter / access sequencer sharing one single-port
//               byte memory between N_REQ requesters. One access every two
//               cycles: ACCESS drives the memory pins, DONE returns the ack and
//               re-arbitrates. All memory pins come straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module multimem_arbiter
    import multimem_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [N_REQ-1:0]          Req,
    input  logic [N_REQ-1:0]          We,
    input  logic [N_REQ*ADDR_W-1:0]   Addr,
    input  logic [N_REQ*DATA_W-1:0]   WData,
    output logic [N_REQ-1:0]          Gnt,
    output logic [N_REQ-1:0]          Ack,
    output logic [DATA_W-1:0]         RData,
    output logic                      Busy,
    output logic [ADDR_W-1:0]         MemAddress,
    output logic [DATA_W-1:0]         MemWriteData,
    output logic                      MemWrite,
    output logic                      MemRead,
    input  logic [DATA_W-1:0]         MemReadData
);

    localparam int               PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] C_ONE = N_REQ'(1);
    localparam logic [PW-1:0]    C_LAST = PW'(N_REQ - 1);

    mm_state_e          state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic [ADDR_W-1:0]  maddr_q, maddr_d;
    logic [DATA_W-1:0]  mwdata_q, mwdata_d;
    logic               mwrite_q, mwrite_d;
    logic               mread_q, mread_d;

    logic [N_REQ-1:0]   w_onehot;
    logic [PW-1:0]      w_idx;
    logic               w_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req_i   (Req),
        .ptr_i   (ptr_q),
        .grant_o (w_onehot),
        .idx_o   (w_idx),
        .valid_o (w_valid)
    );

    // Next-state logic: arbitrate in IDLE/DONE, latch winner into memory pins
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gnt_d    = '0;
        ack_d    = '0;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwrite_d = 1'b0;
        mread_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (w_valid) begin
                    state_d  = ACCESS;
                    busy_d   = 1'b1;
                    gnt_d    = w_onehot;
                    owner_d  = w_idx;
                    ptr_d    = (w_idx == C_LAST) ? '0 : w_idx + 1'b1;
                    maddr_d  = Addr[w_idx*ADDR_W +: ADDR_W];
                    mwdata_d = WData[w_idx*DATA_W +: DATA_W];
                    mwrite_d = We[w_idx];
                    mread_d  = ~We[w_idx];
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            ACCESS: begin
                state_d = DONE;
                busy_d  = 1'b1;
                ack_d   = C_ONE << owner_q;
                // Only reads update RData; write acks leave it untouched
                if (mread_q) begin
                    rdata_d = MemReadData;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset also kills an in-flight strobe
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwrite_q <= 1'b0;
            mread_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mwrite_q <= mwrite_d;
            mread_q  <= mread_d;
        end
    end

    assign Gnt          = gnt_q;
    assign Ack          = ack_q;
    assign RData        = rdata_q;
    assign Busy         = busy_q;
    assign MemAddress   = maddr_q;
    assign MemWriteData = mwdata_q;
    assign MemWrite     = mwrite_q;
    assign MemRead      = mread_q;

endmodule : multimem_arbiter
`default_nettype wire

// File: doc/multimem_arbiter.md
# multimem_arbiter

Round-robin arbiter and access sequencer that shares the single-port 256 x 8 byte memory between up to N requesters (core load/store unit, DMA/copy engine, debug port). Each requester issues one byte read or write with a req/gnt/ack handshake. The arbiter latches the winning request, drives the memory's address, data and strobe pins for exactly one cycle, and returns read data with a one-cycle ack pulse. It sits between the requesters and the memory. It is the only driver of the memory's MemWrite/MemRead.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, byte address width
- DATA_W, 8, data width

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Req  in  N_REQ  request per requester; level; held until its Gnt bit is seen
- We  in  N_REQ  1 = write, 0 = read, per requester
- Addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- WData  in  N_REQ*DATA_W  packed write data, same packing
- Gnt  out  N_REQ  one-hot, registered; pulses 1 cycle when the request is latched
- Ack  out  N_REQ  one-hot, registered; pulses 1 cycle when the access completes
- RData  out  DATA_W  read result; valid in the Ack cycle; holds until the next read completes
- Busy  out  1  high in ACCESS and DONE
- MemAddress  out  ADDR_W  to memory Address
- MemWriteData  out  DATA_W  to memory WriteData
- MemWrite  out  1  to memory MemWrite
- MemRead  out  1  to memory MemRead
- MemReadData  in  DATA_W  from memory ReadData (combinational in memory)

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any Req bit is set, pick the winner by round-robin. Latch its We, Addr and WData, set Gnt[winner], and go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle):
  - MemAddress/MemWriteData carry the latched values.
  - MemWrite = latched We; MemRead = ~latched We.
  - At the closing edge the memory commits a write; for a read, MemReadData is captured into RData.
  - Next state is DONE.
- DONE (1 cycle):
  - Ack[owner] = 1; MemWrite = MemRead = 0.
  - Arbitration runs exactly as in IDLE. If a request wins, go to ACCESS with the new Gnt; otherwise go to IDLE.
- Round-robin rule:
  - Pointer P holds the highest-priority index. The winner is the first set Req bit scanning P, P+1, … mod N_REQ.
  - After a grant to i, P = (i+1) mod N_REQ. P changes only on a grant.
- A granted requester must drop or replace Req at the edge where it sees Gnt. Its Req value during DONE is treated as a new request.
- Write acks leave RData unchanged.
- Addr/WData/We of non-winning requesters are ignored. Changes to them never affect an access in flight.

## Timing
- Reset values: state IDLE, P = 0, and Gnt, Ack, RData, Busy, MemAddress, MemWriteData, MemWrite, MemRead all 0.
- Latency: Req high in cycle T (IDLE) -> Gnt in T+1 (ACCESS) -> Ack and RData valid in T+2.
- Throughput: one access per 2 cycles under continuous requests.
- MemWrite/MemRead are high only in ACCESS and are never high together.
- Memory pins are registered; nothing combinational runs from Req to any Mem* output.
- Reset asserted mid-ACCESS: MemWrite drops asynchronously, the write is not committed, no Ack is issued, and the requester must re-request.
- Simultaneous requests: exactly one Gnt per arbitration; the losers stay pending with no lost requests.
- All Req bits low in DONE: go to IDLE, Busy low next cycle.
- Pointer wrap: a grant to N_REQ-1 sets P = 0.

## Structure
- Package multimem_pkg: ADDR_W/DATA_W defaults and the state enum {IDLE, ACCESS, DONE}.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: Req vector and pointer P.
  - Outputs: one-hot winner, winner index, any-valid flag.
  - Instantiated once.
- Top level: FSM, request latch, pointer register and output registers. Instantiated alongside the byte memory in the memory subsystem.

## Test plan
- Single write then read: req0 writes 0xA5 to 0x3C, then reads 0x3C -> Gnt0 at T+1, Ack0 at T+2 for each; second Ack0 shows RData = 0xA5; MemWrite high for exactly 1 cycle.
- Simultaneous contention: all four requesters read 0x00..0x03 (preloaded 0x10..0x13) starting at P = 0 -> grants in order 0,1,2,3 on cycles T+1, T+3, T+5, T+7; RData 0x10..0x13 in successive Acks.
- Fairness with wrap: req3 and req0 held continuously starting at P = 3 -> grant order 3,0,3,0; P returns to 0 after each grant to 3.
- Write ack preserves data: read of 0x80 (0x5A) then write 0xFF to 0x81 -> RData stays 0x5A through the write Ack; a later read of 0x81 returns 0xFF.
- Reset mid-ACCESS: write 0x77 to 0x10 with Rst_n pulled low during ACCESS -> no Ack, all outputs 0 immediately; after release, a read of 0x10 returns the old value 0x00.
- Idle gap: a single request followed by no Req -> DONE goes to IDLE, Busy falls, and MemRead/MemWrite stay 0 for the idle cycles.
